// File: rtl/full_adder_1bit.sv
// rtl/full_adder_1bit.sv - one-bit full adder cell used by the ripple subtractor
module full_adder_1bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   // Plain gate equations so that X/Z on any input reaches the outputs unmasked
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/sub_nbits.sv
// rtl/sub_nbits.sv - unsigned ripple-carry subtractor with combinational and registered outputs
module sub_nbits #(
   parameter int width = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [width-1:0] a_i,
   input  logic [width-1:0] b_i,
   output logic [width-1:0] s_o,
   output logic             cout_o,
   output logic [width-1:0] s_q_o,
   output logic             cout_q_o
);

   // carry[i] feeds bit i; carry[0] = 1 supplies the +1 of the two's complement of b_i
   logic [width:0]   carry;
   logic [width-1:0] b_inv;
   logic [width-1:0] s_d;
   logic             cout_d;
   logic [width-1:0] s_q;
   logic             cout_q;

   assign carry[0] = 1'b1;
   assign b_inv    = ~b_i;

   // a_i + ~b_i + 1 as a chain of one-bit cells, LSB first
   for (genvar i = 0; i < width; i++) begin : g_fa
      full_adder_1bit u_fa (
         .a    (a_i[i]),
         .b    (b_inv[i]),
         .cin  (carry[i]),
         .s    (s_d[i]),
         .cout (carry[i+1])
      );
   end

   // Final carry is 1 exactly when no borrow occurred (a_i >= b_i)
   assign cout_d = carry[width];

   assign s_o    = s_d;
   assign cout_o = cout_d;

   // Capture the difference every edge; reset clears only the registered copy
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s_q    <= '0;
         cout_q <= 1'b0;
      end else begin
         s_q    <= s_d;
         cout_q <= cout_d;
      end
   end

   assign s_q_o    = s_q;
   assign cout_q_o = cout_q;

endmodule

// File: tb/tb_sub_nbits.sv
// tb/tb_sub_nbits.sv - directed self-checking bench for sub_nbits at width 8
module tb_sub_nbits;

   logic       clk;
   logic       rst;
   logic [7:0] a;
   logic [7:0] b;
   logic [7:0] s;
   logic       cout;
   logic [7:0] s_q;
   logic       cout_q;

   int n_cmp;
   int n_err;

   sub_nbits #(.width(8)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .a_i      (a),
      .b_i      (b),
      .s_o      (s),
      .cout_o   (cout),
      .s_q_o    (s_q),
      .cout_q_o (cout_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hand-computed vectors: {a, b, expected s, expected cout}
   logic [7:0] va [12] = '{8'h05, 8'h03, 8'h00, 8'h80, 8'hA7, 8'hFF, 8'h00, 8'hFF, 8'h7F, 8'hC8, 8'h12, 8'h64};
   logic [7:0] vb [12] = '{8'h03, 8'h05, 8'hFF, 8'h80, 8'h00, 8'hFF, 8'h01, 8'h00, 8'h80, 8'h37, 8'h34, 8'hC8};
   logic [7:0] vs [12] = '{8'h02, 8'hFE, 8'h01, 8'h00, 8'hA7, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h91, 8'hDE, 8'h9C};
   logic       vc [12] = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0};

   task automatic test_reset();
      rst = 1'b1;
      a   = 8'hFF;
      b   = 8'h00;
      @(posedge clk);
      #1;
      n_cmp++;
      if (s_q !== 8'h00) begin n_err++; $display("FAIL reset_s_q: got %h want 00", s_q); end
      n_cmp++;
      if (cout_q !== 1'b0) begin n_err++; $display("FAIL reset_cout_q: got %b want 0", cout_q); end
      n_cmp++;
      if (s !== 8'hFF) begin n_err++; $display("FAIL reset_s_comb: got %h want ff", s); end
      n_cmp++;
      if (cout !== 1'b1) begin n_err++; $display("FAIL reset_cout_comb: got %b want 1", cout); end
      rst = 1'b0;
   endtask

   task automatic test_vectors();
      for (int i = 0; i < 12; i++) begin
         a = va[i];
         b = vb[i];
         #1;
         n_cmp++;
         if (s !== vs[i]) begin n_err++; $display("FAIL vec%0d_s: a=%h b=%h got %h want %h", i, a, b, s, vs[i]); end
         n_cmp++;
         if (cout !== vc[i]) begin n_err++; $display("FAIL vec%0d_cout: a=%h b=%h got %b want %b", i, a, b, cout, vc[i]); end
         @(posedge clk);
         #1;
         n_cmp++;
         if (s_q !== vs[i]) begin n_err++; $display("FAIL vec%0d_s_q: got %h want %h", i, s_q, vs[i]); end
         n_cmp++;
         if (cout_q !== vc[i]) begin n_err++; $display("FAIL vec%0d_cout_q: got %b want %b", i, cout_q, vc[i]); end
      end
   endtask

   task automatic test_reset_midstream();
      a   = 8'h10;
      b   = 8'h01;
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++;
      if (s_q !== 8'h0F || cout_q !== 1'b1) begin n_err++; $display("FAIL mid_pre: got %h/%b want 0f/1", s_q, cout_q); end
      rst = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++;
      if (s_q !== 8'h00 || cout_q !== 1'b0) begin n_err++; $display("FAIL mid_rst: got %h/%b want 00/0", s_q, cout_q); end
      n_cmp++;
      if (s !== 8'h0F || cout !== 1'b1) begin n_err++; $display("FAIL mid_comb: got %h/%b want 0f/1", s, cout); end
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++;
      if (s_q !== 8'h0F || cout_q !== 1'b1) begin n_err++; $display("FAIL mid_post: got %h/%b want 0f/1", s_q, cout_q); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] prev_s;
      logic       prev_c;
      a = va[0];
      b = vb[0];
      @(posedge clk);
      #1;
      for (int i = 1; i < 12; i++) begin
         prev_s = vs[i-1];
         prev_c = vc[i-1];
         a = va[i];
         b = vb[i];
         #1;
         n_cmp++;
         if (s_q !== prev_s || cout_q !== prev_c) begin
            n_err++;
            $display("FAIL b2b%0d_hold: got %h/%b want %h/%b", i, s_q, cout_q, prev_s, prev_c);
         end
         @(posedge clk);
         #1;
         n_cmp++;
         if (s_q !== vs[i] || cout_q !== vc[i]) begin
            n_err++;
            $display("FAIL b2b%0d_cap: got %h/%b want %h/%b", i, s_q, cout_q, vs[i], vc[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] exp_s;
      logic       exp_c;
      for (int i = 0; i < 12; i++) begin
         a = 8'($urandom_range(0, 255));
         b = 8'($urandom_range(0, 255));
         exp_s = 8'((int'(a) - int'(b) + 256) % 256);
         exp_c = (a >= b);
         #5;
         n_cmp++;
         if (s !== exp_s || cout !== exp_c) begin
            n_err++;
            $display("FAIL rand%0d: a=%h b=%h got %h/%b want %h/%b", i, a, b, s, cout, exp_s, exp_c);
         end
         #5;
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b1;
      a     = 8'h00;
      b     = 8'h00;
      @(negedge clk);
      test_reset();
      test_vectors();
      test_reset_midstream();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
